// File: rtl/commit_queue_pkg.sv
// Shared types for the in-order commit queue: scoreboard entry, exception record and sizing.
package commit_queue_pkg;

   localparam int unsigned XLEN               = 64;
   localparam int unsigned TRANS_ID_BITS      = 3;
   localparam int unsigned COMMIT_QUEUE_DEPTH = 8;

   typedef enum logic [2:0] {
      FuNone,
      FuAlu,
      FuLoad,
      FuStore,
      FuBranch,
      FuMult,
      FuCsr
   } fu_t;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

   typedef struct packed {
      logic [XLEN-1:0]          pc;
      logic [TRANS_ID_BITS-1:0] trans_id;
      fu_t                      fu;
      logic [7:0]               op;
      logic [4:0]               rs1;
      logic [4:0]               rs2;
      logic [4:0]               rd;
      logic [XLEN-1:0]          result;
      logic                     valid;
      exception_t               ex;
   } scoreboard_entry_t;

endpackage

// File: rtl/commit_queue.sv
// In-order retire queue: allocate at tail on issue, complete by trans_id on writeback,
// present the oldest entries to commit and pop them on acknowledge.
module commit_queue
   import commit_queue_pkg::*;
#(
   parameter int unsigned NR_ENTRIES      = COMMIT_QUEUE_DEPTH,
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned NR_WB_PORTS     = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic                          issue_valid_i,
   input  scoreboard_entry_t             issue_instr_i,
   output logic                          issue_ready_o,
   output logic [TRANS_ID_BITS-1:0]      issue_trans_id_o,
   input  logic [NR_WB_PORTS-1:0]        wb_valid_i,
   input  logic [TRANS_ID_BITS-1:0]      wb_trans_id_i [NR_WB_PORTS],
   input  logic [XLEN-1:0]               wb_result_i   [NR_WB_PORTS],
   input  exception_t                    wb_ex_i       [NR_WB_PORTS],
   output scoreboard_entry_t             commit_instr_o [NR_COMMIT_PORTS],
   input  logic [NR_COMMIT_PORTS-1:0]    commit_ack_i,
   output logic [$clog2(NR_ENTRIES):0]   count_o
);

   localparam int unsigned IDX_BITS = $clog2(NR_ENTRIES);

   typedef logic [IDX_BITS:0]   ptr_t;
   typedef logic [IDX_BITS-1:0] idx_t;

   ptr_t                  head_q, head_d;
   ptr_t                  tail_q, tail_d;
   scoreboard_entry_t     mem_q [NR_ENTRIES];
   scoreboard_entry_t     mem_d [NR_ENTRIES];
   logic [NR_ENTRIES-1:0] occ_q, occ_d;
   logic [NR_ENTRIES-1:0] fin_q, fin_d;
   logic [NR_ENTRIES-1:0] wb_hit;

   logic [NR_COMMIT_PORTS-1:0] commit_valid;
   ptr_t                       pop_cnt;
   logic                       full;
   logic                       issue_fire;
   idx_t                       tail_idx;

   function automatic idx_t slot_at(ptr_t base, int unsigned offset);
      return base[IDX_BITS-1:0] + idx_t'(offset);
   endfunction

   assign tail_idx         = tail_q[IDX_BITS-1:0];
   assign full             = (head_q[IDX_BITS] != tail_q[IDX_BITS]) &&
                             (head_q[IDX_BITS-1:0] == tail_q[IDX_BITS-1:0]);
   assign count_o          = tail_q - head_q;
   assign issue_ready_o    = !full && !flush_i;
   assign issue_fire       = issue_valid_i && issue_ready_o;
   assign issue_trans_id_o = TRANS_ID_BITS'(tail_idx);

   // Commit ports read registered state only, so writeback shows up one cycle later.
   always_comb begin
      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
         commit_valid[i]         = occ_q[slot_at(head_q, i)] && fin_q[slot_at(head_q, i)] &&
                                   (count_o > ptr_t'(i));
         commit_instr_o[i]       = mem_q[slot_at(head_q, i)];
         commit_instr_o[i].valid = commit_valid[i];
      end
   end

   // A port only pops if every older port pops too; out-of-order acks are dropped.
   always_comb begin
      pop_cnt = '0;
      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
         if (commit_ack_i[i] && commit_valid[i] && (pop_cnt == ptr_t'(i))) begin
            pop_cnt = pop_cnt + ptr_t'(1);
         end
      end
   end

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      mem_d  = mem_q;
      occ_d  = occ_q;
      fin_d  = fin_q;
      wb_hit = '0;

      // Ascending scan with a claim mask: the lowest port targeting an entry wins outright.
      for (int unsigned w = 0; w < NR_WB_PORTS; w++) begin
         if (wb_valid_i[w] && occ_q[idx_t'(wb_trans_id_i[w])] &&
             !fin_q[idx_t'(wb_trans_id_i[w])] && !wb_hit[idx_t'(wb_trans_id_i[w])]) begin
            wb_hit[idx_t'(wb_trans_id_i[w])]       = 1'b1;
            fin_d[idx_t'(wb_trans_id_i[w])]        = 1'b1;
            mem_d[idx_t'(wb_trans_id_i[w])].result = wb_result_i[w];
            if (wb_ex_i[w].valid) begin
               mem_d[idx_t'(wb_trans_id_i[w])].ex = wb_ex_i[w];
            end
         end
      end

      if (issue_fire) begin
         mem_d[tail_idx]       = issue_instr_i;
         mem_d[tail_idx].valid = 1'b0;
         occ_d[tail_idx]       = 1'b1;
         fin_d[tail_idx]       = issue_instr_i.ex.valid;
         tail_d                = tail_q + ptr_t'(1);
      end

      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
         if (ptr_t'(i) < pop_cnt) begin
            occ_d[slot_at(head_q, i)] = 1'b0;
            fin_d[slot_at(head_q, i)] = 1'b0;
         end
      end
      head_d = head_q + pop_cnt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         fin_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         fin_q  <= fin_d;
      end
   end

   // Payload needs no reset: occupancy bits gate everything that reads it.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

`ifndef SYNTHESIS
   if (NR_COMMIT_PORTS == 2) begin : g_ack_order
      a_ack_order : assert property (@(posedge clk_i) disable iff (rst_i)
         !(commit_ack_i[NR_COMMIT_PORTS-1] && !commit_ack_i[0]));
   end

   a_ack_valid : assert property (@(posedge clk_i) disable iff (rst_i)
      (commit_ack_i & ~commit_valid) == '0);

   a_no_alloc_when_busy : assert property (@(posedge clk_i) disable iff (rst_i)
      (issue_valid_i && !issue_ready_o && !flush_i) |=> $stable(tail_q));
`endif

endmodule
